// File: rtl/stream_mux_n.sv
// stream_mux_n: N-channel valid/ready stream multiplexer with packet-level
// grant locking and a one-entry registered output stage.
//
// Build option: define STREAM_MUX_RR_EN for round-robin arbitration between
// packets. When it is undefined, the lowest valid channel index wins whenever
// the arbiter is idle, and no rotation pointer is built.
//
// A multi-beat packet keeps the grant until its last beat has been accepted.
// If the locked channel stalls mid-packet, the output simply bubbles; no
// other channel is allowed to interleave its beats into that packet.

// Per-channel accept logic. Each lane decides on its own whether it is the
// granted channel this cycle.
module stream_mux_n_lane #(
    parameter int CW  = 2,
    parameter int IDX = 0
) (
    input  logic [CW-1:0] win,
    input  logic          win_vld,
    input  logic          valid,
    input  logic          load_en,
    input  logic          reset,
    output logic          ready
);

    // Accept only if this lane holds the grant, has a beat, and the output slot can load.
    always_comb begin
        ready = !reset && load_en && win_vld && valid && (win == CW'(IDX));
    end

endmodule

module stream_mux_n #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [CW-1:0]        out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Contents of the output register, kept together so it loads as one unit.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
        logic [CW-1:0]    chan;
    } beat_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CW-1:0]            lock_chan;
    logic [CW-1:0]            lock_nxt;

    logic [N-1:0][WIDTH-1:0]  lane_data;
    logic [CW-1:0]            win;
    logic                     win_vld;
    logic                     load_en;
    logic                     accept;
    logic                     acc_last;
    beat_t                    out_q;
    beat_t                    acc_beat;

    // Split the flat input bus into one word per channel.
    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign lane_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // The output slot can take a new beat if it is empty or is draining this cycle.
    assign load_en  = !out_valid || out_ready;
    assign accept   = |in_ready;
    assign acc_last = in_last[win];

    assign acc_beat.data = lane_data[win];
    assign acc_beat.last = acc_last;
    assign acc_beat.chan = win;

`ifdef STREAM_MUX_RR_EN
    logic [CW-1:0] rr_ptr;

    // Winner select: a locked packet keeps its channel; when idle, scan from
    // the rotation pointer upward with wrap at N. The scan runs backwards, so
    // the last assignment made is the first match in rotation order.
    always_comb begin
        int j;
        j       = 0;
        win     = '0;
        win_vld = 1'b0;
        if (state == LOCKED) begin
            win     = lock_chan;
            win_vld = in_valid[lock_chan];
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                j = int'(rr_ptr) + k;
                if (j >= N) begin
                    j = j - N;
                end
                if (in_valid[j]) begin
                    win     = CW'(j);
                    win_vld = 1'b1;
                end
            end
        end
    end

    // Move the pointer past the channel that finished a packet. The wrap is
    // taken at N, not at 2^CW, so a non-power-of-two N never sees a hole index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept && acc_last) begin
            rr_ptr <= (win == CW'(N - 1)) ? '0 : win + CW'(1);
        end
    end
`else
    // Winner select: a locked packet keeps its channel; when idle, the lowest
    // valid index wins. The scan runs backwards so the lowest index is the
    // last assignment made.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        if (state == LOCKED) begin
            win     = lock_chan;
            win_vld = in_valid[lock_chan];
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (in_valid[k]) begin
                    win     = CW'(k);
                    win_vld = 1'b1;
                end
            end
        end
    end
`endif

    // One accept lane per channel. At most one lane can match the winner index.
    for (genvar i = 0; i < N; i++) begin : g_lane
        stream_mux_n_lane #(
            .CW  (CW),
            .IDX (i)
        ) u_lane (
            .win     (win),
            .win_vld (win_vld),
            .valid   (in_valid[i]),
            .load_en (load_en),
            .reset   (reset),
            .ready   (in_ready[i])
        );
    end

    // Arbiter state register: the lock state and the locked channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lock_chan <= '0;
        end else begin
            state     <= state_nxt;
            lock_chan <= lock_nxt;
        end
    end

    // Next state: the first beat of a multi-beat packet takes the lock, and
    // the last beat of that packet releases it.
    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_chan;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!acc_last) begin
                        state_nxt = LOCKED;
                        lock_nxt  = win;
                    end
                end
                LOCKED: begin
                    if (acc_last) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output register. It loads on accept and empties on drain. The payload
    // holds its value while the slot is empty, so nothing downstream sees a
    // spurious change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_q     <= acc_beat;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_data = out_q.data;
    assign out_last = out_q.last;
    assign out_chan = out_q.chan;

endmodule
